// File: rtl/snake_game_sequencer.sv
// snake_game_sequencer: game-step controller for the snake datapath.
// Paces move ticks from the velocity, hands one step to the position
// controller, scores apples, detects collisions and respawns the apple.
`timescale 1ns/1ps
module snake_game_sequencer #(
  parameter int unsigned TICK_BASE  = 25_000_000,
  parameter int unsigned TICK_STEP  = 2_000_000,
  parameter int unsigned MIN_PERIOD = 5_000_000,
  parameter int unsigned HIT_WIN    = 4,
  parameter int unsigned MAX_LEN    = 99,
  parameter int unsigned VMAX       = 15
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic [9:0]  head_x,
  input  logic [9:0]  head_y,
  input  logic        self_hit,
  input  logic        wall_hit,
  input  logic        move_done,
  input  logic [9:0]  rand_x,
  input  logic [9:0]  rand_y,
  output logic        move_req,
  output logic [9:0]  apple_x,
  output logic [9:0]  apple_y,
  output logic [19:0] score,
  output logic [19:0] high_score,
  output logic [9:0]  length,
  output logic [7:0]  velocity,
  output logic        apple_eaten,
  output logic [2:0]  game_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    MOVE  = 3'd2,
    CHECK = 3'd3,
    SPAWN = 3'd4,
    OVER  = 3'd5
  } state_t;

  localparam logic [9:0]         APPLE_X0  = 10'd160;
  localparam logic [9:0]         APPLE_Y0  = 10'd320;
  localparam logic [19:0]        SCORE_MAX = 20'd9999;
  localparam logic [31:0]        BASE32    = 32'(TICK_BASE);
  localparam logic [31:0]        STEP32    = 32'(TICK_STEP);
  localparam logic [31:0]        MIN32     = 32'(MIN_PERIOD);
  localparam logic signed [10:0] HIT_LIM   = 11'(HIT_WIN);

  state_t      state, next_state;
  logic        start_p1;
  logic        start_edge;
  logic [31:0] tick_cnt;
  logic [31:0] vel_steps, reduction, period;
  logic        tick_done;
  logic [9:0]  head_x_p1, head_y_p1;
  logic        self_hit_p1, wall_hit_p1;
  logic        collision, apple_hit, rand_ok;
  logic [2:0]  mod6_cnt;
  logic [2:0]  spawn_cnt;

  // True when both axes of (ax,ay) are within the hit half-window of (bx,by);
  // differences are taken 11-bit signed so nothing wraps near zero.
  function automatic logic in_window(input logic [9:0] ax, input logic [9:0] ay,
                                     input logic [9:0] bx, input logic [9:0] by);
    logic signed [10:0] dx, dy, adx, ady;
    dx  = $signed({1'b0, ax}) - $signed({1'b0, bx});
    dy  = $signed({1'b0, ay}) - $signed({1'b0, by});
    adx = (dx < 0) ? -dx : dx;
    ady = (dy < 0) ? -dy : dy;
    return (adx <= HIT_LIM) && (ady <= HIT_LIM);
  endfunction

  // Score plus velocity squared, clamped to what the 4-digit display shows.
  function automatic logic [19:0] sat_score(input logic [19:0] s, input logic [7:0] v);
    logic [15:0] sq;
    logic [19:0] sum;
    sq  = 16'(v) * 16'(v);
    sum = s + {4'd0, sq};
    return (sum > SCORE_MAX) ? SCORE_MAX : sum;
  endfunction

  function automatic logic [9:0] sat_len(input logic [9:0] l);
    return (l >= 10'(MAX_LEN)) ? 10'(MAX_LEN) : l + 10'd1;
  endfunction

  function automatic logic [7:0] sat_vel(input logic [7:0] v);
    return (v >= 8'(VMAX)) ? 8'(VMAX) : v + 8'd1;
  endfunction

  assign start_edge = start & ~start_p1;
  assign collision  = self_hit_p1 | wall_hit_p1;
  assign apple_hit  = in_window(head_x_p1, head_y_p1, apple_x, apple_y);
  assign rand_ok    = (rand_x >= 10'd8) && (rand_x <= 10'd631) &&
                      (rand_y >= 10'd8) && (rand_y <= 10'd471) &&
                      !in_window(rand_x, rand_y, head_x_p1, head_y_p1);
  assign tick_done  = (tick_cnt >= period - 32'd1);
  assign game_state = state;

  // Move period from velocity, floored at MIN_PERIOD without underflow.
  always_comb begin
    vel_steps = 32'(velocity) - 32'd2;
    reduction = vel_steps * STEP32;
    period    = BASE32 - reduction;
    if ((reduction >= BASE32) || ((BASE32 - reduction) < MIN32)) period = MIN32;
  end

  // Game-level state register.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state selection for the game step sequence.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_edge) next_state = WAIT;
      WAIT:    if (!pause && tick_done) next_state = MOVE;
      MOVE:    if (move_done) next_state = CHECK;
      CHECK: begin
        if (collision)      next_state = OVER;
        else if (apple_hit) next_state = SPAWN;
        else                next_state = WAIT;
      end
      SPAWN:   if (rand_ok || spawn_cnt == 3'd7) next_state = WAIT;
      OVER:    if (start_edge) next_state = WAIT;
      default: next_state = IDLE;
    endcase
  end

  // Registered start level for edge detection and the step request.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      start_p1 <= 1'b0;
      move_req <= 1'b0;
    end else begin
      start_p1 <= start;
      move_req <= (next_state == MOVE);
    end
  end

  // Tick counter: runs in WAIT, frozen by pause, cleared when the tick fires.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) tick_cnt <= 32'd0;
    else if (state == WAIT && !pause) tick_cnt <= tick_done ? 32'd0 : tick_cnt + 32'd1;
  end

  // ---- stage p1: capture head and collision flags at the move acknowledge ----
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      head_x_p1   <= 10'd0;
      head_y_p1   <= 10'd0;
      self_hit_p1 <= 1'b0;
      wall_hit_p1 <= 1'b0;
    end else if (state == MOVE && move_done) begin
      head_x_p1   <= head_x;
      head_y_p1   <= head_y;
      self_hit_p1 <= self_hit;
      wall_hit_p1 <= wall_hit;
    end
  end

  // Counts rejected spawn samples within one SPAWN visit.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) spawn_cnt <= 3'd0;
    else       spawn_cnt <= (state == SPAWN && next_state == SPAWN) ? spawn_cnt + 3'd1 : 3'd0;
  end

  // Scoring, growth, velocity ramp, apple placement and restart clearing.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      score       <= 20'd0;
      length      <= 10'd0;
      velocity    <= 8'd2;
      mod6_cnt    <= 3'd0;
      apple_eaten <= 1'b0;
      apple_x     <= APPLE_X0;
      apple_y     <= APPLE_Y0;
    end else begin
      apple_eaten <= 1'b0;
      if (state == CHECK && !collision && apple_hit) begin
        score       <= sat_score(score, velocity);
        length      <= sat_len(length);
        apple_eaten <= 1'b1;
        if (mod6_cnt == 3'd5) begin
          mod6_cnt <= 3'd0;
          velocity <= sat_vel(velocity);
        end else begin
          mod6_cnt <= mod6_cnt + 3'd1;
        end
      end
      if (state == SPAWN) begin
        if (rand_ok) begin
          apple_x <= rand_x;
          apple_y <= rand_y;
        end else if (spawn_cnt == 3'd7) begin
          apple_x <= APPLE_X0;
          apple_y <= APPLE_Y0;
        end
      end
      if (state == OVER && start_edge) begin
        score    <= 20'd0;
        length   <= 10'd0;
        velocity <= 8'd2;
        mod6_cnt <= 3'd0;
        apple_x  <= APPLE_X0;
        apple_y  <= APPLE_Y0;
      end
    end
  end

  // Best score follows the running score whenever it is exceeded.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) high_score <= 20'd0;
    else if (score > high_score) high_score <= score;
  end

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Bench for snake_game_sequencer: directed step table, long all-hit run to
// saturation, randomized steps against a transaction-level game model.
`timescale 1ns/1ps
module tb_snake_game_sequencer;

  localparam int TB_BASE = 100;
  localparam int TB_STEP = 10;
  localparam int TB_MIN  = 20;
  localparam int HW      = 4;
  localparam int MAXL    = 99;
  localparam int VM      = 15;

  logic        clock_100Mhz = 1'b0;
  logic        reset, start, pause;
  logic [9:0]  head_x, head_y;
  logic        self_hit, wall_hit, move_done;
  logic [9:0]  rand_x, rand_y;
  logic        move_req;
  logic [9:0]  apple_x, apple_y;
  logic [19:0] score, high_score;
  logic [9:0]  length;
  logic [7:0]  velocity;
  logic        apple_eaten;
  logic [2:0]  game_state;

  snake_game_sequencer #(
    .TICK_BASE(TB_BASE), .TICK_STEP(TB_STEP), .MIN_PERIOD(TB_MIN)
  ) dut (
    .clock_100Mhz(clock_100Mhz), .reset(reset), .start(start), .pause(pause),
    .head_x(head_x), .head_y(head_y), .self_hit(self_hit), .wall_hit(wall_hit),
    .move_done(move_done), .rand_x(rand_x), .rand_y(rand_y), .move_req(move_req),
    .apple_x(apple_x), .apple_y(apple_y), .score(score), .high_score(high_score),
    .length(length), .velocity(velocity), .apple_eaten(apple_eaten),
    .game_state(game_state)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  int cyc = 0;
  always @(posedge clock_100Mhz) cyc <= cyc + 1;

  typedef struct { int hx; int hy; bit sh; bit wh; int mvc; } stim_t;
  typedef struct { int eaten; int score; int len; int vel; int ax; int ay; int st; int spawn; } res_t;
  typedef struct { stim_t s; int r0x; int r0y; int r1x; int r1y; int pause_len; res_t e; } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int last_mark, exp_gap;
  int rx[8], ry[8];
  int m_score, m_len, m_vel, m_apples, m_ax, m_ay, m_high;
  vec_t  tbl[10];
  vec_t  v;
  stim_t s;
  res_t  e;
  int    tbl_high, seen, kind;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  function automatic int period_of(input int vel);
    int p;
    p = TB_BASE - (vel - 2) * TB_STEP;
    return (p < TB_MIN) ? TB_MIN : p;
  endfunction

  function automatic bit near(input int ax, input int ay, input int bx, input int by);
    int dx, dy;
    dx = ax - bx; if (dx < 0) dx = -dx;
    dy = ay - by; if (dy < 0) dy = -dy;
    return (dx <= HW) && (dy <= HW);
  endfunction

  // Game rules applied to one whole step; updates the model and yields expectations.
  task automatic model_step(input stim_t st, output res_t r);
    bit found;
    r.eaten = 0; r.spawn = 0;
    if (st.sh || st.wh) begin
      r.st = 5;
    end else if (near(st.hx, st.hy, m_ax, m_ay)) begin
      m_score = m_score + m_vel * m_vel;
      if (m_score > 9999) m_score = 9999;
      if (m_len < MAXL) m_len = m_len + 1;
      m_apples = m_apples + 1;
      if ((m_apples % 6 == 0) && (m_vel < VM)) m_vel = m_vel + 1;
      r.eaten = 1; r.st = 4;
      found = 0;
      for (int k = 0; k < 8; k++) begin
        if (!found && rx[k] >= 8 && rx[k] <= 631 && ry[k] >= 8 && ry[k] <= 471 &&
            !near(rx[k], ry[k], st.hx, st.hy)) begin
          found = 1; m_ax = rx[k]; m_ay = ry[k]; r.spawn = k + 1;
        end
      end
      if (!found) begin m_ax = 160; m_ay = 320; r.spawn = 8; end
    end else begin
      r.st = 1;
    end
    if (m_score > m_high) m_high = m_score;
    r.score = m_score; r.len = m_len; r.vel = m_vel; r.ax = m_ax; r.ay = m_ay;
  endtask

  task automatic gen_rand();
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        rx[k] = int'($urandom_range(8, 631)); ry[k] = int'($urandom_range(8, 471));
      end else begin
        rx[k] = int'($urandom_range(0, 1023)); ry[k] = int'($urandom_range(0, 1023));
      end
    end
  endtask

  // Start edge from IDLE or OVER; resets the model (keeping the best score).
  task automatic do_restart(input string tag);
    start = 1'b1;
    last_mark = cyc + 1;
    @(negedge clock_100Mhz);
    start = 1'b0;
    m_score = 0; m_len = 0; m_vel = 2; m_apples = 0; m_ax = 160; m_ay = 320;
    exp_gap = period_of(2);
    chk({tag, "_state"}, int'(game_state), 1);
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_length"}, int'(length), 0);
    chk({tag, "_velocity"}, int'(velocity), 2);
    chk({tag, "_apple_x"}, int'(apple_x), 160);
    chk({tag, "_apple_y"}, int'(apple_y), 320);
    chk({tag, "_high"}, int'(high_score), m_high);
  endtask

  // One full game step: wait for the request, acknowledge, follow CHECK/SPAWN.
  task automatic run_step(input stim_t st, input res_t r, input int exp_high, input string tag);
    int guard, k;
    guard = 0;
    while (move_req !== 1'b1 && guard < 2000) begin
      @(negedge clock_100Mhz);
      guard++;
    end
    if (move_req !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_req_timeout: move_req still %b after %0d cycles", tag, move_req, guard);
      return;
    end
    chk({tag, "_gap"}, cyc - last_mark, exp_gap);
    last_mark = cyc;
    chk({tag, "_st_move"}, int'(game_state), 2);
    repeat (st.mvc - 1) @(negedge clock_100Mhz);
    head_x = 10'(st.hx); head_y = 10'(st.hy);
    self_hit = st.sh; wall_hit = st.wh; move_done = 1'b1;
    @(negedge clock_100Mhz);
    move_done = 1'b0; self_hit = 1'b0; wall_hit = 1'b0;
    chk({tag, "_req_drop"}, int'(move_req), 0);
    chk({tag, "_st_check"}, int'(game_state), 3);
    @(negedge clock_100Mhz);
    chk({tag, "_eaten"}, int'(apple_eaten), r.eaten);
    chk({tag, "_score"}, int'(score), r.score);
    chk({tag, "_length"}, int'(length), r.len);
    chk({tag, "_velocity"}, int'(velocity), r.vel);
    chk({tag, "_st_after"}, int'(game_state), r.st);
    if (r.st == 4) begin
      k = 0;
      while (game_state == 3'd4 && k < 12) begin
        rand_x = 10'(rx[(k > 7) ? 7 : k]); rand_y = 10'(ry[(k > 7) ? 7 : k]);
        @(negedge clock_100Mhz);
        k++;
      end
      chk({tag, "_spawn_cycles"}, k, r.spawn);
      chk({tag, "_eaten_off"}, int'(apple_eaten), 0);
      chk({tag, "_st_wait"}, int'(game_state), 1);
    end
    chk({tag, "_apple_x"}, int'(apple_x), r.ax);
    chk({tag, "_apple_y"}, int'(apple_y), r.ay);
    chk({tag, "_high"}, int'(high_score), exp_high);
    exp_gap = period_of(r.vel) + st.mvc + 1 + ((r.st == 4) ? r.spawn : 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    //              hx   hy  sh    wh    mvc  r0x  r0y  r1x  r1y  pause  eat scr len vel ax   ay  st spawn
    tbl[0] = '{'{400, 400, 1'b0, 1'b0, 2}, 0,   0,   0,   0,   0,   '{0, 0,  0, 2, 160, 320, 1, 0}};
    tbl[1] = '{'{162, 317, 1'b0, 1'b0, 2}, 300, 200, 300, 200, 500, '{1, 4,  1, 2, 300, 200, 4, 1}};
    tbl[2] = '{'{296, 204, 1'b0, 1'b0, 1}, 700, 10,  700, 10,  0,   '{1, 8,  2, 2, 160, 320, 4, 8}};
    tbl[3] = '{'{160, 320, 1'b0, 1'b0, 3}, 160, 320, 50,  50,  0,   '{1, 12, 3, 2, 50,  50,  4, 2}};
    tbl[4] = '{'{46,  54,  1'b0, 1'b0, 2}, 631, 471, 0,   0,   0,   '{1, 16, 4, 2, 631, 471, 4, 1}};
    tbl[5] = '{'{636, 471, 1'b0, 1'b0, 2}, 0,   0,   0,   0,   0,   '{0, 16, 4, 2, 631, 471, 1, 0}};
    tbl[6] = '{'{627, 467, 1'b0, 1'b0, 2}, 7,   100, 8,   8,   0,   '{1, 20, 5, 2, 8,   8,   4, 2}};
    tbl[7] = '{'{4,   12,  1'b0, 1'b0, 2}, 632, 100, 8,   14,  0,   '{1, 24, 6, 3, 160, 320, 4, 8}};
    tbl[8] = '{'{100, 100, 1'b0, 1'b0, 2}, 0,   0,   0,   0,   0,   '{0, 24, 6, 3, 160, 320, 1, 0}};
    tbl[9] = '{'{160, 320, 1'b1, 1'b0, 2}, 0,   0,   0,   0,   0,   '{0, 24, 6, 3, 160, 320, 5, 0}};

    reset = 1'b1; start = 1'b0; pause = 1'b0; move_done = 1'b0;
    head_x = '0; head_y = '0; self_hit = 1'b0; wall_hit = 1'b0; rand_x = '0; rand_y = '0;
    repeat (3) @(negedge clock_100Mhz);
    chk("rst_state", int'(game_state), 0);
    chk("rst_move_req", int'(move_req), 0);
    chk("rst_apple_x", int'(apple_x), 160);
    chk("rst_apple_y", int'(apple_y), 320);
    chk("rst_score", int'(score), 0);
    chk("rst_high", int'(high_score), 0);
    chk("rst_length", int'(length), 0);
    chk("rst_velocity", int'(velocity), 2);
    chk("rst_eaten", int'(apple_eaten), 0);
    reset = 1'b0;
    repeat (5) @(negedge clock_100Mhz);
    chk("idle_hold_state", int'(game_state), 0);
    chk("idle_hold_req", int'(move_req), 0);

    m_high = 0;
    do_restart("start");

    tbl_high = 0;
    for (int i = 0; i < 10; i++) begin
      v = tbl[i];
      rx[0] = v.r0x; ry[0] = v.r0y;
      for (int k = 1; k < 8; k++) begin rx[k] = v.r1x; ry[k] = v.r1y; end
      if (v.e.score > tbl_high) tbl_high = v.e.score;
      run_step(v.s, v.e, tbl_high, $sformatf("vec%0d", i));
      if (v.pause_len > 0) begin
        repeat (3) @(negedge clock_100Mhz);
        pause = 1'b1;
        seen = 0;
        repeat (v.pause_len) begin
          @(negedge clock_100Mhz);
          if (move_req === 1'b1) seen = 1;
        end
        pause = 1'b0;
        chk($sformatf("vec%0d_pause_no_req", i), seen, 0);
        exp_gap = exp_gap + v.pause_len;
      end
    end

    m_high = tbl_high;
    do_restart("restart1");

    for (int i = 0; i < 110; i++) begin
      s.hx = m_ax + int'($urandom_range(0, 8)) - 4;
      s.hy = m_ay + int'($urandom_range(0, 8)) - 4;
      s.sh = 1'b0; s.wh = 1'b0;
      s.mvc = int'($urandom_range(1, 4));
      gen_rand();
      model_step(s, e);
      run_step(s, e, m_high, $sformatf("sat%0d", i));
    end
    chk("sat_velocity_cap", int'(velocity), 15);
    chk("sat_score_cap", int'(score), 9999);
    chk("sat_length_cap", int'(length), 99);

    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 9));
      s.sh = 1'b0; s.wh = 1'b0;
      s.mvc = int'($urandom_range(1, 5));
      if (kind == 0) begin
        s.hx = int'($urandom_range(0, 1023)); s.hy = int'($urandom_range(0, 1023));
        case ($urandom_range(0, 2))
          0:       s.sh = 1'b1;
          1:       s.wh = 1'b1;
          default: begin s.sh = 1'b1; s.wh = 1'b1; end
        endcase
      end else if (kind <= 5) begin
        s.hx = m_ax + int'($urandom_range(0, 8)) - 4;
        s.hy = m_ay + int'($urandom_range(0, 8)) - 4;
      end else begin
        s.hx = m_ax + (($urandom_range(0, 1) == 1) ? 1 : -1) * int'($urandom_range(5, 8));
        s.hy = m_ay + int'($urandom_range(0, 8)) - 4;
      end
      gen_rand();
      model_step(s, e);
      run_step(s, e, m_high, $sformatf("rnd%0d", i));
      if (e.st == 5) do_restart($sformatf("rnd%0d_restart", i));
    end

    seen = 0;
    while (move_req !== 1'b1 && seen < 2000) begin
      @(negedge clock_100Mhz);
      seen++;
    end
    chk("rst_mid_move_req_seen", int'(move_req), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_move_req", int'(move_req), 0);
    chk("rst_mid_state", int'(game_state), 0);
    chk("rst_mid_high", int'(high_score), 0);
    chk("rst_mid_score", int'(score), 0);
    chk("rst_mid_velocity", int'(velocity), 2);
    @(negedge clock_100Mhz);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
